// File: rtl/array_reverse_io_buffer.sv
// Per-thread, per-lane receive buffer behind the lane-reversing I/O queue.
// Ports: clock/reset, in/in_wren -> in_full, rd_en -> out/out_empty, thread.
module array_reverse_io_buffer #(
  parameter int WORD_WIDTH        = 36,
  parameter int LANE_COUNT        = 8,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WORD_WIDTH*LANE_COUNT-1:0] in,
  input  logic [LANE_COUNT-1:0]            in_wren,
  output logic [LANE_COUNT-1:0]            in_full,
  input  logic [LANE_COUNT-1:0]            rd_en,
  output logic [WORD_WIDTH*LANE_COUNT-1:0] out,
  output logic [LANE_COUNT-1:0]            out_empty,
  output logic [THREAD_ADDR_WIDTH-1:0]     thread
);

  localparam int TW = THREAD_ADDR_WIDTH;
  localparam int W  = WORD_WIDTH;
  localparam int L  = LANE_COUNT;

  logic [TW-1:0] thread_q, thread_d;

  logic [THREAD_COUNT-1:0][L-1:0] full_q, full_d;
  logic [W-1:0] mem_q [THREAD_COUNT][L];

  logic [W*L-1:0] out_q, out_d;
  logic [L-1:0]   empty_q, empty_d;
  logic [L-1:0]   infull_q, infull_d;
  logic [L-1:0]   wr_ok;
  logic [L-1:0]   f_cur;

  always_comb begin
    if (thread_q == TW'(THREAD_COUNT - 1))
      thread_d = '0;
    else
      thread_d = thread_q + TW'(1);

    f_cur    = full_q[thread_q];
    full_d   = full_q;
    out_d    = out_q;
    empty_d  = '0;
    infull_d = '0;
    wr_ok    = '0;

    for (int l = 0; l < L; l++) begin
      // A read in the same cycle frees the slot, so a write into a
      // full slot is accepted only when it is also being read.
      wr_ok[l] = in_wren[l] & (~f_cur[l] | rd_en[l]);

      if (rd_en[l] & f_cur[l]) begin
        out_d[l*W +: W]  = mem_q[thread_q][l];
        full_d[thread_q][l] = 1'b0;
      end

      empty_d[l]  = rd_en[l] & ~f_cur[l];
      infull_d[l] = in_wren[l] & f_cur[l] & ~rd_en[l];

      if (wr_ok[l])
        full_d[thread_q][l] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      thread_q <= '0;
      full_q   <= '0;
      out_q    <= '0;
      empty_q  <= '0;
      infull_q <= '0;
    end else begin
      thread_q <= thread_d;
      full_q   <= full_d;
      out_q    <= out_d;
      empty_q  <= empty_d;
      infull_q <= infull_d;
    end
  end

  // Data words carry no reset; the full bits alone say what is valid.
  always_ff @(posedge clock) begin
    for (int l = 0; l < L; l++) begin
      if (wr_ok[l] && !reset)
        mem_q[thread_q][l] <= in[l*W +: W];
    end
  end

  assign thread    = thread_q;
  assign out       = out_q;
  assign out_empty = empty_q;
  assign in_full   = infull_q;

endmodule

// File: tb/tb_array_reverse_io_buffer.sv
// Directed bench for array_reverse_io_buffer (8 and 6 thread builds).
// Table of single-lane operations plus hand-written corner sequences.
module tb_array_reverse_io_buffer;

  localparam int W = 36;
  localparam int L = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [W*L-1:0] din;
  logic [L-1:0] in_wren;
  logic [L-1:0] in_full;
  logic [L-1:0] rd_en;
  logic [W*L-1:0] dout;
  logic [L-1:0] out_empty;
  logic [2:0]   thr;

  logic         reset6;
  logic [W*L-1:0] din6;
  logic [L-1:0] in_wren6;
  logic [L-1:0] in_full6;
  logic [L-1:0] rd_en6;
  logic [W*L-1:0] dout6;
  logic [L-1:0] out_empty6;
  logic [2:0]   thr6;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  array_reverse_io_buffer #(
    .WORD_WIDTH(W), .LANE_COUNT(L),
    .THREAD_COUNT(8), .THREAD_ADDR_WIDTH(3)
  ) dut (
    .clock(clock), .reset(reset),
    .in(din), .in_wren(in_wren), .in_full(in_full),
    .rd_en(rd_en), .out(dout), .out_empty(out_empty),
    .thread(thr)
  );

  array_reverse_io_buffer #(
    .WORD_WIDTH(W), .LANE_COUNT(L),
    .THREAD_COUNT(6), .THREAD_ADDR_WIDTH(3)
  ) dut6 (
    .clock(clock), .reset(reset6),
    .in(din6), .in_wren(in_wren6), .in_full(in_full6),
    .rd_en(rd_en6), .out(dout6), .out_empty(out_empty6),
    .thread(thr6)
  );

  typedef struct {
    int          t;
    int          lane;
    bit          wr;
    bit          rd;
    logic [W-1:0] din;
    logic [W-1:0] eout;
    bit          e;
    bit          f;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [W*L-1:0] act,
                     input logic [W*L-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_thr(input bit six, input int t);
    int n;
    n = 0;
    while (int'(six ? thr6 : thr) != t && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (int'(six ? thr6 : thr) != t) begin
      n_fail++;
      $display("FAIL wait_thread: got %0d expected %0d",
               six ? thr6 : thr, t);
    end
  endtask

  task automatic idle_in();
    din     = '0;
    in_wren = '0;
    rd_en   = '0;
  endtask

  logic [W*L-1:0] rep_a, rep_b;

  initial begin
    idle_in();
    din6     = '0;
    in_wren6 = '0;
    rd_en6   = '0;
    reset    = 1'b1;
    reset6   = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    reset6 = 1'b0;

    // Idle: thread walks 0..7 twice, outputs stay at reset values.
    for (int i = 0; i < 16; i++) begin
      chk("idle_thread", W*L'(thr), W*L'(i % 8));
      chk("idle_out", dout, '0);
      chk("idle_flags", {out_empty, in_full}, '0);
      tick();
    end

    // t, lane, wr, rd, din, expected out lane, out_empty, in_full
    vecs.push_back('{3, 0, 1, 0, 36'h123456789, 36'h0, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 36'h0, 36'h123456789, 0, 0});
    vecs.push_back('{3, 0, 0, 1, 36'h0, 36'h123456789, 1, 0});
    vecs.push_back('{2, 1, 1, 0, 36'h1, 36'h0, 0, 0});
    vecs.push_back('{2, 1, 1, 1, 36'h2, 36'h1, 0, 0});
    vecs.push_back('{2, 1, 0, 1, 36'h0, 36'h2, 0, 0});
    vecs.push_back('{2, 1, 0, 1, 36'h0, 36'h2, 1, 0});
    vecs.push_back('{4, 2, 1, 0, 36'hA, 36'h0, 0, 0});
    vecs.push_back('{4, 2, 1, 0, 36'hB, 36'h0, 0, 1});
    vecs.push_back('{4, 2, 0, 1, 36'h0, 36'hA, 0, 0});
    vecs.push_back('{4, 2, 1, 1, 36'hC, 36'hA, 1, 0});
    vecs.push_back('{4, 2, 0, 1, 36'h0, 36'hC, 0, 0});

    foreach (vecs[i]) begin
      wait_thr(1'b0, vecs[i].t);
      din[vecs[i].lane*W +: W] = vecs[i].din;
      in_wren[vecs[i].lane]    = vecs[i].wr;
      rd_en[vecs[i].lane]      = vecs[i].rd;
      tick();
      idle_in();
      chk($sformatf("vec%0d_out", i),
          W*L'(dout[vecs[i].lane*W +: W]), W*L'(vecs[i].eout));
      chk($sformatf("vec%0d_empty", i),
          W*L'(out_empty), W*L'(L'(vecs[i].e) << vecs[i].lane));
      chk($sformatf("vec%0d_full", i),
          W*L'(in_full), W*L'(L'(vecs[i].f) << vecs[i].lane));
    end

    // Thread 5, all lanes: overflow drops the second word.
    for (int l = 0; l < L; l++) begin
      rep_a[l*W +: W] = 36'hA;
      rep_b[l*W +: W] = 36'hB;
    end
    wait_thr(1'b0, 5);
    din = rep_a;
    in_wren = '1;
    tick();
    idle_in();
    chk("all_wr_full", W*L'(in_full), '0);
    wait_thr(1'b0, 5);
    din = rep_b;
    in_wren = '1;
    tick();
    idle_in();
    chk("all_overflow", W*L'(in_full), W*L'(8'hFF));
    wait_thr(1'b0, 5);
    rd_en = '1;
    tick();
    idle_in();
    chk("all_read_old", dout, rep_a);
    chk("all_read_empty", W*L'(out_empty), '0);

    // Fill lane 7 on every thread, then reset mid-round.
    wait_thr(1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      din[7*W +: W] = W'(36'h10 + i);
      in_wren[7] = 1'b1;
      tick();
    end
    idle_in();
    chk("fill_no_overflow", W*L'(in_full), '0);
    wait_thr(1'b0, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_thread", W*L'(thr), '0);
    chk("rst_out", dout, '0);
    chk("rst_flags", {out_empty, in_full}, '0);
    for (int i = 0; i < 8; i++) begin
      rd_en[7] = 1'b1;
      tick();
      chk($sformatf("rst_empty_t%0d", i),
          W*L'(out_empty), W*L'(8'h80));
      chk($sformatf("rst_out_t%0d", i), dout, '0);
    end
    idle_in();

    // Six-thread build: wrap 5 -> 0 and slot 5 round trip.
    wait_thr(1'b1, 5);
    din6[W-1:0] = 36'h55;
    in_wren6[0] = 1'b1;
    tick();
    in_wren6 = '0;
    din6 = '0;
    chk("six_wrap", W*L'(thr6), '0);
    for (int i = 0; i < 5; i++) tick();
    chk("six_back", W*L'(thr6), W*L'(5));
    rd_en6[0] = 1'b1;
    tick();
    rd_en6 = '0;
    chk("six_out", W*L'(dout6[W-1:0]), W*L'(36'h55));
    chk("six_empty", W*L'(out_empty6), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/array_reverse_io_buffer.md
Name: array_reverse_io_buffer

Overview:
- Per-thread, per-lane I/O receive buffer directly downstream of the lane-reversing I/O queue.
- Captures the reversed words as they emerge, THREAD_COUNT cycles after the issuing thread's write, into a slot owned by that thread.
- Presents the slots to the lanes' I/O read ports with Octavo-style empty/full flags, so threads stall instead of reading stale data or overwriting unread data.

Parameters:
- WORD_WIDTH, 36, bits per lane word.
- LANE_COUNT, 8, number of SIMD lanes.
- THREAD_COUNT, 8, number of round-robin threads; any value >= 2, not required to be a power of two.
- THREAD_ADDR_WIDTH, 3, width of the thread counter; must satisfy 2^THREAD_ADDR_WIDTH >= THREAD_COUNT.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WORD_WIDTH*LANE_COUNT  lane-packed words from the reversing queue; lane i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- in_wren  input  LANE_COUNT  per-lane write strobe qualifying in.
- in_full  output  LANE_COUNT  per-lane overflow flag: write attempted into a full slot.
- rd_en  input  LANE_COUNT  per-lane read request from the lane I/O read port.
- out  output  WORD_WIDTH*LANE_COUNT  lane-packed read data.
- out_empty  output  LANE_COUNT  per-lane flag: read attempted on an empty slot (stall).
- thread  output  THREAD_ADDR_WIDTH  current thread counter.

Behaviour:
- Storage: THREAD_COUNT x LANE_COUNT data words, each with one full bit.
- Thread counter:
  - reset -> 0; increments by 1 every cycle; wraps from THREAD_COUNT-1 to 0.
  - Both write and read in a cycle address slot[thread][lane]. The reversing queue depth equals THREAD_COUNT, so returning data belongs to the currently issuing thread.
- Reset values: thread=0, all full bits 0, out=0, out_empty=0, in_full=0. Stored data words are not cleared.
- Reset mid-operation: all full bits clear in the same cycle; pending data is discarded; in_full and out_empty read 0 on the cycle after reset.
- Per lane L, with t = thread in cycle N, f = full[t][L]:
  - Read, rd_en=1, f=1: out lane L <= data[t][L] at N+1; out_empty[L]=0 at N+1; full cleared unless a write in the same cycle refills it.
  - Read, rd_en=1, f=0: out lane L holds its previous value; out_empty[L]=1 at N+1; no state change from the read.
  - rd_en=0: out lane L holds; out_empty[L]=0 at N+1.
  - Write, in_wren=1, f=0: data[t][L] <= in lane L; full <= 1; in_full[L]=0 at N+1.
  - Write, in_wren=1, f=1, rd_en=0: data is dropped; slot unchanged; in_full[L]=1 at N+1.
  - Write, in_wren=1, f=1, rd_en=1: read returns the old word; new word is stored; full stays 1; in_full[L]=0 at N+1.
  - Write, in_wren=1, f=0, rd_en=1: read reports empty (out_empty=1); write is stored; full <= 1.
- Flags are single-cycle pulses; they are not sticky.
- Lanes are fully independent; no cross-lane interaction.
- Latency: 1 cycle from request to out, out_empty and in_full.
- A thread sees its own slot again exactly THREAD_COUNT cycles later.

Test Plan:
- Reset, then idle 2*THREAD_COUNT cycles -> thread sequences 0..7,0..7; out=0; out_empty=0; in_full=0.
- Thread 3, lane 0: write 0x123456789 -> next thread-3 cycle, rd_en[0]=1 -> out lane 0 = 0x123456789 one cycle later, out_empty[0]=0; the following thread-3 read gives out_empty[0]=1.
- Thread 5, all lanes: write 0xA, then next round write 0xB with rd_en=0 -> in_full=all ones; a subsequent read returns 0xA, not 0xB.
- Thread 2, slot full with 0x1: simultaneous write 0x2 and read -> out=0x1; next round read -> out=0x2; in_full stays 0.
- Fill threads 0..7 lane 7 with 0x10+t, pulse reset at thread 4 mid-round, then read all threads -> out_empty[7]=1 for every thread; thread restarts at 0.
- THREAD_COUNT=6, THREAD_ADDR_WIDTH=3 -> thread wraps 5->0; slot for thread 5 is written and read back correctly.
